tcache_refill_ctrl: RTL
=======================

Name: tcache_refill_ctrl

Overview:
- Owns the texture cache tag/valid array. Sequences line refills and cache flushes for the texture cache BRAM.
- Accepts one miss at a time from the lookup pipeline and issues a TileLink-UH Get for the 128-byte line (opcode 4, size 7).
- Streams the 32 response beats into the data BRAM, then commits the tag.
- Arbitrates flush against refill.

Parameters:
LINES, 16, number of direct-mapped lines; index width IW = log2(LINES) = 4
BEATS, 32, 32-bit beats per line; beat counter width BW = log2(BEATS) = 5
TAG_W, 21, tag width = 32 - IW - log2(BEATS*4) = 32 - 4 - 7

Ports:
core_clock_i  in  1  single clock
core_reset_i  in  1  asynchronous, active-high reset
miss_valid_i  in  1  miss request from lookup stage
miss_addr_i  in  32  byte address of the miss
miss_ready_o  out  1  miss accepted when miss_valid_i and miss_ready_o are both high
flush_i  in  1  flush request, single-cycle pulse
flush_done_o  out  1  one-cycle pulse when the flush completes
lookup_idx_i  in  IW  index to probe
lookup_tag_i  in  TAG_W  tag to compare
lookup_hit_o  out  1  combinational hit; high when valid[idx] is set and tag[idx] equals lookup_tag_i
tcache_a_opcode  out  3  held at 4 (Get)
tcache_a_param  out  3  held at 0
tcache_a_size  out  4  held at 7
tcache_a_address  out  32  line-aligned address
tcache_a_mask  out  4  held at 4'hF
tcache_a_data  out  32  held at 0
tcache_a_corrupt  out  1  held at 0
tcache_a_valid  out  1  A-channel request valid
tcache_a_ready  in  1  A-channel ready
tcache_d_data  in  32  response beat data
tcache_d_denied  in  1  response denied flag
tcache_d_valid  in  1  response beat valid
tcache_d_ready  out  1  D-channel ready
bram_we_o  out  1  BRAM word write strobe
bram_waddr_o  out  IW+BW  BRAM word address, {index, beat}
bram_wdata_o  out  32  BRAM write data
refill_done_o  out  1  one-cycle pulse after the last beat
refill_err_o  out  1  valid together with refill_done_o; high if any beat was denied

Behaviour:
- States: IDLE, FLUSH, REQ, RESP.
- Reset (asynchronous) forces: state IDLE; all valid bits 0; flush_pend 0; all counters 0.
- Outputs at reset: tcache_a_valid 0, tcache_d_ready 0, bram_we_o 0, flush_done_o 0, refill_done_o 0, refill_err_o 0, tcache_a_address 0.
- Reset mid-refill abandons the transaction. Remaining D beats after reset are the interconnect's concern.
- flush_pend is set by flush_i in any state. It is cleared on entry to FLUSH.
- miss_ready_o = (state==IDLE) && !flush_pend && !flush_i.
- IDLE:
  - flush_pend or flush_i → FLUSH. Flush has priority over miss.
  - Otherwise a miss handshake captures idx = miss_addr_i[10:7] and tag = miss_addr_i[31:11], and clears valid[idx] in the same edge.
  - On that handshake: tcache_a_address <= {miss_addr_i[31:7], 7'b0}; tcache_a_valid <= 1; state → REQ.
- REQ:
  - tcache_a_valid stays high and the address stays stable until tcache_a_ready is sampled high.
  - On that edge: tcache_a_valid <= 0; beat counter <= 0; denied_acc <= 0; state → RESP.
  - The earliest D beat accepted is therefore 1 cycle after the A handshake.
- RESP:
  - tcache_d_ready = 1 (combinational on state).
  - Each beat with tcache_d_valid high drives, combinationally in that cycle: bram_we_o = 1, bram_waddr_o = {idx, beat}, bram_wdata_o = tcache_d_data.
  - Each such beat also does beat <= beat+1 and denied_acc <= denied_acc | tcache_d_denied.
  - Cycles without tcache_d_valid produce no write and no count.
  - On the beat where beat == BEATS-1: tag[idx] <= tag, and valid[idx] <= !(denied_acc | tcache_d_denied).
  - The cycle after that beat: refill_done_o = 1 and refill_err_o = the final denied value; state → IDLE.
- FLUSH:
  - One line per cycle: valid[fcnt] <= 0, fcnt <= fcnt+1.
  - On fcnt == LINES-1: fcnt wraps to 0; next cycle flush_done_o pulses; state → IDLE.
  - A flush always takes LINES cycles.
- Flush during REQ or RESP: latched in flush_pend and serviced immediately after the refill returns to IDLE. A new miss is not accepted first.
- lookup_hit_o for the line being refilled reads 0 from miss acceptance until the tag commits. It reads 1 from the edge after the last good beat.
- Simultaneous cases:
  - flush_i together with the last refill beat: the refill completes and commits, then FLUSH clears the line.
  - A second flush_i during FLUSH is absorbed into flush_pend and re-runs the flush.

Test Plan:
- Reset, then miss_addr_i=32'h0001_2345 → A request with address 32'h0001_2300, opcode 4, size 7, mask F.
  - Hold tcache_a_ready low 3 cycles: a_valid and address stay stable.
  - Then send 32 beats, data = beat number: bram_waddr_o = 9'h0C0..9'h0DF with matching data.
  - refill_done_o=1, refill_err_o=0.
  - lookup_idx_i=6, lookup_tag_i=21'h24 → hit=1.
- Refill with tcache_d_valid gapped every other cycle → exactly 32 writes; done only after the 32nd beat.
- Refill with tcache_d_denied=1 on beat 5 → refill_err_o=1; lookup of that line gives hit=0.
- Fill lines 0 and 3, then pulse flush_i → miss_ready_o=0 for 16 cycles; flush_done_o pulse; hits on lines 0 and 3 = 0.
- flush_i pulsed during RESP beat 10 → refill completes normally, then FLUSH runs. A miss held valid is accepted only after flush_done_o.
- Assert core_reset_i during RESP beat 12 → outputs at reset values immediately; all lookups miss; a subsequent miss is accepted normally.

Source files
------------

// File: rtl/tcache_refill_ctrl.sv
// Texture cache refill/flush controller.
// Owns the direct-mapped tag/valid array, fetches 128-byte lines over a
// TileLink-UH Get, streams the response beats into the data BRAM and
// commits the tag. A flush clears every valid bit, one line per cycle.
module tcache_refill_ctrl #(
    parameter int LINES = 16,
    parameter int BEATS = 32,
    parameter int TAG_W = 21,
    localparam int IW = $clog2(LINES),
    localparam int BW = $clog2(BEATS)
) (
    input  logic             core_clock_i,
    input  logic             core_reset_i,
    input  logic             miss_valid_i,
    input  logic [31:0]      miss_addr_i,
    output logic             miss_ready_o,
    input  logic             flush_i,
    output logic             flush_done_o,
    input  logic [IW-1:0]    lookup_idx_i,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             lookup_hit_o,
    output logic [2:0]       tcache_a_opcode,
    output logic [2:0]       tcache_a_param,
    output logic [3:0]       tcache_a_size,
    output logic [31:0]      tcache_a_address,
    output logic [3:0]       tcache_a_mask,
    output logic [31:0]      tcache_a_data,
    output logic             tcache_a_corrupt,
    output logic             tcache_a_valid,
    input  logic             tcache_a_ready,
    input  logic [31:0]      tcache_d_data,
    input  logic             tcache_d_denied,
    input  logic             tcache_d_valid,
    output logic             tcache_d_ready,
    output logic             bram_we_o,
    output logic [IW+BW-1:0] bram_waddr_o,
    output logic [31:0]      bram_wdata_o,
    output logic             refill_done_o,
    output logic             refill_err_o
);

    // Byte offset within a line: beat index plus 2 bits of byte-in-word.
    localparam int OFS = BW + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        REQ   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               flush_pend;
    logic [IW-1:0]      fcnt;
    logic [BW-1:0]      beat;
    logic               denied_acc;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [IW-1:0]      idx_r;
    logic [TAG_W-1:0]   tag_r;
    logic [31:0]        a_addr;
    logic               a_vld;
    logic               done_r;
    logic               err_r;
    logic               fdone_r;

    logic               miss_rdy;
    logic               d_rdy;
    logic               miss_fire;
    logic               a_fire;
    logic               beat_fire;
    logic               last_beat;
    logic               flush_last;
    logic               enter_flush;
    logic               beat_denied;

    logic [IW-1:0]      miss_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic               unused_low;

    assign miss_idx    = miss_addr_i[OFS +: IW];
    assign miss_tag    = miss_addr_i[31 -: TAG_W];
    assign unused_low  = ^miss_addr_i[OFS-1:0];
    assign beat_denied = denied_acc | tcache_d_denied;

    // State register; reset abandons any refill in flight.
    always_ff @(posedge core_clock_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state handshake strobes. Flush beats miss in IDLE.
    always_comb begin
        state_nxt   = state;
        miss_rdy    = 1'b0;
        d_rdy       = 1'b0;
        miss_fire   = 1'b0;
        a_fire      = 1'b0;
        beat_fire   = 1'b0;
        last_beat   = 1'b0;
        flush_last  = 1'b0;
        enter_flush = 1'b0;
        case (state)
            IDLE: begin
                miss_rdy = !flush_pend && !flush_i;
                if (flush_pend || flush_i) begin
                    state_nxt   = FLUSH;
                    enter_flush = 1'b1;
                end else if (miss_valid_i) begin
                    state_nxt = REQ;
                    miss_fire = 1'b1;
                end
            end
            FLUSH: begin
                if (fcnt == IW'(LINES - 1)) begin
                    flush_last = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            REQ: begin
                if (tcache_a_ready) begin
                    a_fire    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                d_rdy = 1'b1;
                if (tcache_d_valid) begin
                    beat_fire = 1'b1;
                    if (beat == BW'(BEATS - 1)) begin
                        last_beat = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: flush latch, counters, valid bits, A-channel request and done pulses.
    always_ff @(posedge core_clock_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            flush_pend <= 1'b0;
            fcnt       <= '0;
            beat       <= '0;
            denied_acc <= 1'b0;
            valid      <= '0;
            a_addr     <= '0;
            a_vld      <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            fdone_r    <= 1'b0;
        end else begin
            // Entering FLUSH consumes the request; otherwise any flush pulse is remembered.
            if (enter_flush) begin
                flush_pend <= 1'b0;
            end else if (flush_i) begin
                flush_pend <= 1'b1;
            end
            if (state == FLUSH) begin
                valid[fcnt] <= 1'b0;
                fcnt        <= fcnt + 1'b1;
            end
            // The line is invalidated at acceptance so lookups never see stale data.
            if (miss_fire) begin
                valid[miss_idx] <= 1'b0;
                a_addr          <= {miss_addr_i[31:OFS], OFS'(0)};
                a_vld           <= 1'b1;
            end
            if (a_fire) begin
                a_vld      <= 1'b0;
                beat       <= '0;
                denied_acc <= 1'b0;
            end
            if (beat_fire) begin
                beat       <= beat + 1'b1;
                denied_acc <= beat_denied;
            end
            if (last_beat) begin
                valid[idx_r] <= !beat_denied;
            end
            done_r  <= last_beat;
            err_r   <= last_beat && beat_denied;
            fdone_r <= flush_last;
        end
    end

    // Miss index/tag capture and tag commit; valid bits gate these, so no reset needed.
    always_ff @(posedge core_clock_i) begin
        if (miss_fire) begin
            idx_r <= miss_idx;
            tag_r <= miss_tag;
        end
        if (last_beat) begin
            tag_mem[idx_r] <= tag_r;
        end
    end

    assign miss_ready_o     = miss_rdy;
    assign flush_done_o     = fdone_r;
    assign lookup_hit_o     = valid[lookup_idx_i] && (tag_mem[lookup_idx_i] == lookup_tag_i);

    assign tcache_a_opcode  = 3'd4;
    assign tcache_a_param   = 3'd0;
    assign tcache_a_size    = 4'd7;
    assign tcache_a_address = a_addr;
    assign tcache_a_mask    = 4'hF;
    assign tcache_a_data    = 32'd0;
    assign tcache_a_corrupt = 1'b0;
    assign tcache_a_valid   = a_vld;
    assign tcache_d_ready   = d_rdy;

    assign bram_we_o        = beat_fire;
    assign bram_waddr_o     = {idx_r, beat};
    assign bram_wdata_o     = tcache_d_data;

    assign refill_done_o    = done_r;
    assign refill_err_o     = err_r;

endmodule
